cube_psum_accumulator: RTL and testbench
========================================

// Module: cube_psum_accumulator
// PURPOSE
//   Downstream stage of the N x N x N MAC cube. Tracks each issued operand tile through the
//   cube pipeline and sums the N*N per-tile partial results over a K-tile group into
//   OUT_WIDTH signed accumulators. It then drains each finished N x N tile row by row over
//   a valid/ready stream. Accumulate and drain banks are separate, so the drain of group g
//   overlaps the accumulation of group g+1.
// PARAMETERS
//   N          8                       cube edge; tile is N x N, result bus has N*N lanes
//   WIDTH      8                       operand width; sets cube result width
//   ACC_WIDTH  2*WIDTH+$clog2(N)       width of one signed cube result lane
//   OUT_WIDTH  32                      signed accumulator / output lane width (>= ACC_WIDTH)
//   CUBE_LAT   N+1                     cycles from operand issue edge to result-valid edge
// PORTS
//   clk            in   1                   clock, rising edge
//   rst_n          in   1                   asynchronous active-low reset
//   i_issue        in   1                   operand tile presented to cube this cycle
//   i_first        in   1                   qualifies i_issue: first K-tile of a group
//   i_last         in   1                   qualifies i_issue: last K-tile of a group
//   o_issue_ready  out  1                   upstream may issue; issue while low is dropped
//   i_result       in   N*N*ACC_WIDTH       cube result; lane (z,x) at [(N*z+x)*ACC_WIDTH +: ACC_WIDTH]
//   o_valid        out  1                   output row valid
//   i_ready        in   1                   downstream accepts row
//   o_data         out  N*OUT_WIDTH         row z, lane x at [x*OUT_WIDTH +: OUT_WIDTH]
//   o_row          out  $clog2(N)           row index z of o_data
//   o_row_last     out  1                   o_data is row N-1 (last beat of tile)
//   o_drop         out  1                   sticky: an issue arrived while o_issue_ready low
// BEHAVIOUR
//   Reset: all outputs 0 except o_issue_ready=1; tag pipe, banks, FSMs cleared; o_drop cleared.
//   Tag pipe: CUBE_LAT-deep shift register of {vld,first,last}; accepted issue at edge t lands
//     at edge t+CUBE_LAT, when i_result is sampled. No gaps, no stalls inside the pipe.
//   Accepted issue = i_issue & o_issue_ready. A dropped issue sets o_drop and enters nothing.
//   Landing, per lane: first (or bank idle) -> acc <= sext(lane); else acc <= sat(acc+sext(lane)).
//     sat = signed saturation to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; never wraps.
//   first&last together = single-tile group. A first on an open group restarts it; the old
//     partial sum is discarded.
//   Accum FSM: A_IDLE -> A_RUN on first landing; A_RUN -> A_DONE on last landing.
//     A_DONE -> A_IDLE on swap, when drain FSM is D_IDLE; swap copies bank and occurs at the
//     earliest edge after A_DONE entry with drain idle.
//   o_issue_ready = 0 from accepted last-issue until its group is swapped into drain bank;
//     otherwise 1. No new group can land while a completed group is unswapped.
//   Drain FSM: D_IDLE -> D_OUT on swap (o_valid=1, o_row=0 after swap edge).
//     In D_OUT, beat accepted when o_valid&i_ready; o_row increments; o_data/o_row stable while
//     i_ready=0. Accept at o_row=N-1 (o_row_last=1) -> D_IDLE, o_valid=0 next cycle.
//     A swap may coincide with the final-beat accept edge (back-to-back tiles, no bubble).
//   Minimum latency: last issue at edge t -> o_valid high after edge t+CUBE_LAT+1.
//   Landings continue into accum bank regardless of i_ready; back-pressure only gates swap.
//   Reset mid-operation: in-flight tags discarded; stale i_result after reset never lands.
// TESTING
//   1) Reset: o_valid=0, o_issue_ready=1, o_drop=0; feed i_result=all 1 with no issue -> no output.
//   2) Group of 3 tiles, lane values 100, 200, -50 (all lanes) -> 8 rows, every lane = 250,
//      first o_valid CUBE_LAT+2 cycles after last issue; o_row 0..7, o_row_last on row 7.
//   3) OUT_WIDTH=20, 3 tiles of 262143 per lane -> every lane 524287 (saturated); repeat with
//      -262144 x3 -> -524288.
//   4) i_ready=0 for 20 cycles during row 3 while next group (first&last, value 7) lands ->
//      row 3 held stable; o_issue_ready low; after drain completes, next tile outputs all 7.
//   5) Issue while o_issue_ready=0 -> o_drop=1 and sticky; sums unchanged (still 250).
//   6) rst_n pulsed low with 2 tiles in flight -> no o_valid after release; next 1-tile
//      group of value 5 outputs 5 in every lane.

Source files
------------

// File: rtl/cube_psum_accumulator.sv
`default_nettype none
// cube_psum_accumulator (rev 1.0): sums K-tile partial results from the MAC cube into
// saturating accumulators and drains each finished N x N tile row by row over valid/ready.
module cube_psum_accumulator #(
  parameter int N         = 8,
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 2*WIDTH + $clog2(N),
  parameter int OUT_WIDTH = 32,
  parameter int CUBE_LAT  = N + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_issue,
  input  logic                       i_first,
  input  logic                       i_last,
  output logic                       o_issue_ready,
  input  logic [N*N*ACC_WIDTH-1:0]   i_result,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [N*OUT_WIDTH-1:0]     o_data,
  output logic [$clog2(N)-1:0]       o_row,
  output logic                       o_row_last,
  output logic                       o_drop
);
  localparam int RW = $clog2(N);
  localparam logic signed [OUT_WIDTH-1:0] SAT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] SAT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {A_IDLE, A_RUN, A_DONE} acc_state_e;
  typedef enum logic       {D_IDLE, D_OUT}         drn_state_e;

  acc_state_e                  acc_state_q, acc_state_d;
  drn_state_e                  drn_state_q, drn_state_d;
  logic [CUBE_LAT-1:0]         tag_vld_q, tag_vld_d;
  logic [CUBE_LAT-1:0]         tag_first_q, tag_first_d;
  logic [CUBE_LAT-1:0]         tag_last_q, tag_last_d;
  logic signed [OUT_WIDTH-1:0] acc_q [N][N];
  logic signed [OUT_WIDTH-1:0] acc_d [N][N];
  logic signed [OUT_WIDTH-1:0] drain_q [N][N];
  logic signed [OUT_WIDTH-1:0] drain_d [N][N];
  logic [RW-1:0]               row_q, row_d;
  logic                        pend_q, pend_d;
  logic                        drop_q, drop_d;

  logic issue_acc, land, land_first, land_last, restart, beat, final_beat, swap;

  function automatic logic signed [OUT_WIDTH-1:0] sext(input logic signed [ACC_WIDTH-1:0] v);
    return OUT_WIDTH'(v);
  endfunction

  // One extra bit of headroom detects overflow of a single add.
  function automatic logic signed [OUT_WIDTH-1:0] sat_add(input logic signed [OUT_WIDTH-1:0] a,
                                                          input logic signed [OUT_WIDTH-1:0] b);
    logic [OUT_WIDTH:0] s;
    s = {a[OUT_WIDTH-1], a} + {b[OUT_WIDTH-1], b};
    if (s[OUT_WIDTH] != s[OUT_WIDTH-1]) return s[OUT_WIDTH] ? SAT_MIN : SAT_MAX;
    return s[OUT_WIDTH-1:0];
  endfunction

  always_comb begin
    issue_acc   = i_issue & o_issue_ready;
    land        = tag_vld_q[CUBE_LAT-1];
    land_first  = tag_first_q[CUBE_LAT-1];
    land_last   = tag_last_q[CUBE_LAT-1];
    beat        = o_valid & i_ready;
    final_beat  = beat && (row_q == RW'(N-1));
    swap        = (acc_state_q == A_DONE) && ((drn_state_q == D_IDLE) || final_beat);
    restart     = land_first || (acc_state_q == A_IDLE);

    tag_vld_d   = {tag_vld_q[CUBE_LAT-2:0], issue_acc};
    tag_first_d = {tag_first_q[CUBE_LAT-2:0], issue_acc & i_first};
    tag_last_d  = {tag_last_q[CUBE_LAT-2:0], issue_acc & i_last};

    acc_state_d = acc_state_q;
    acc_d       = acc_q;
    if (swap) begin
      acc_state_d = A_IDLE;
    end else if (land && (acc_state_q != A_DONE)) begin
      for (int z = 0; z < N; z++) begin
        for (int x = 0; x < N; x++) begin
          acc_d[z][x] = restart ? sext(i_result[(N*z+x)*ACC_WIDTH +: ACC_WIDTH])
                                : sat_add(acc_q[z][x], sext(i_result[(N*z+x)*ACC_WIDTH +: ACC_WIDTH]));
        end
      end
      acc_state_d = land_last ? A_DONE : A_RUN;
    end

    drn_state_d = drn_state_q;
    row_d       = row_q;
    drain_d     = drain_q;
    if (beat) begin
      if (final_beat) begin
        drn_state_d = D_IDLE;
        row_d       = '0;
      end else begin
        row_d = row_q + RW'(1);
      end
    end
    // A swap on the final-beat edge starts the next tile with no bubble.
    if (swap) begin
      drn_state_d = D_OUT;
      row_d       = '0;
      drain_d     = acc_q;
    end

    pend_d = pend_q;
    if (issue_acc && i_last) pend_d = 1'b1;
    if (swap)                pend_d = 1'b0;
    drop_d = drop_q | (i_issue & ~o_issue_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_state_q <= A_IDLE;
      drn_state_q <= D_IDLE;
      tag_vld_q   <= '0;
      tag_first_q <= '0;
      tag_last_q  <= '0;
      acc_q       <= '{default: '0};
      drain_q     <= '{default: '0};
      row_q       <= '0;
      pend_q      <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      acc_state_q <= acc_state_d;
      drn_state_q <= drn_state_d;
      tag_vld_q   <= tag_vld_d;
      tag_first_q <= tag_first_d;
      tag_last_q  <= tag_last_d;
      acc_q       <= acc_d;
      drain_q     <= drain_d;
      row_q       <= row_d;
      pend_q      <= pend_d;
      drop_q      <= drop_d;
    end
  end

  assign o_issue_ready = ~pend_q;
  assign o_valid       = (drn_state_q == D_OUT);
  assign o_row         = row_q;
  assign o_row_last    = o_valid && (row_q == RW'(N-1));
  assign o_drop        = drop_q;

  for (genvar gx = 0; gx < N; gx++) begin : g_lane
    assign o_data[gx*OUT_WIDTH +: OUT_WIDTH] = drain_q[row_q][gx];
  end

endmodule
`default_nettype wire

// File: tb/tb_cube_psum_accumulator.sv
`default_nettype none
// tb_cube_psum_accumulator: directed and randomized checks against a transaction-level model.
module tb_cube_psum_accumulator;
  localparam int N   = 8;
  localparam int AW  = 19;
  localparam int OW  = 20;
  localparam int LAT = N + 1;
  localparam int RB  = N*N*AW;
  localparam longint MAXV = (64'sd1 <<< (OW-1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (OW-1));

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_issue = 1'b0, i_first = 1'b0, i_last = 1'b0;
  logic          o_issue_ready;
  logic [RB-1:0] i_result = '1;
  logic          o_valid;
  logic          i_ready = 1'b1;
  logic [N*OW-1:0] o_data;
  logic [2:0]    o_row;
  logic          o_row_last;
  logic          o_drop;

  cube_psum_accumulator #(.N(N), .WIDTH(8), .OUT_WIDTH(OW), .CUBE_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .i_issue(i_issue), .i_first(i_first), .i_last(i_last),
    .o_issue_ready(o_issue_ready), .i_result(i_result), .o_valid(o_valid), .i_ready(i_ready),
    .o_data(o_data), .o_row(o_row), .o_row_last(o_row_last), .o_drop(o_drop));

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;
  int cyc = 0;
  logic [RB-1:0] sched [int];
  bit rand_rdy = 0, hold_rdy = 1;

  typedef struct { int land; bit f; bit l; } tag_t;
  tag_t   pipe[$];
  longint m_sum [N*N];
  longint m_tile[N*N];
  longint cap   [N*N];
  bit     m_open = 0, m_done = 0, m_drain = 0, m_ready = 1, m_drop = 0;
  int     m_row = 0, m_swaps = 0, tiles_out = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
  endtask

  function automatic longint lane(input logic [RB-1:0] r, input int l);
    logic signed [AW-1:0] s;
    s = r[l*AW +: AW];
    return longint'(s);
  endfunction

  function automatic longint clamp(input longint v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  function automatic logic [RB-1:0] uni(input int v);
    logic [RB-1:0] r;
    for (int l = 0; l < N*N; l++) r[l*AW +: AW] = AW'(v);
    return r;
  endfunction

  function automatic logic [RB-1:0] rnd_tile();
    logic [RB-1:0] r;
    bit big;
    big = ($urandom_range(0, 2) == 0);
    for (int l = 0; l < N*N; l++)
      r[l*AW +: AW] = big ? AW'($urandom) : AW'(int'($urandom_range(0, 2000)) - 1000);
    return r;
  endfunction

  // cube stand-in: presents each tile's data in the cycle it is due to land
  always @(negedge clk) i_result = sched.exists(cyc) ? sched[cyc] : '1;

  always @(posedge clk) begin
    #2;
    i_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : hold_rdy;
  end

  // reference model: advances once per edge from the inputs seen at that edge
  always @(posedge clk) begin
    bit acc_i, beat, fin, swap, done_pre;
    logic [N*OW-1:0] er;
    if (o_valid && i_ready) begin
      for (int x = 0; x < N; x++) cap[int'(o_row)*N + x] = longint'($signed(o_data[x*OW +: OW]));
      if (o_row_last) tiles_out++;
    end
    if (!rst_n) begin
      pipe.delete();
      m_open = 0; m_done = 0; m_drain = 0; m_row = 0; m_ready = 1; m_drop = 0;
    end else begin
      acc_i = i_issue && m_ready;
      if (i_issue && !m_ready) m_drop = 1;
      beat     = m_drain && i_ready;
      fin      = beat && (m_row == N-1);
      done_pre = m_done;
      swap     = done_pre && (!m_drain || fin);
      if (pipe.size() > 0 && pipe[0].land == cyc) begin
        tag_t t;
        t = pipe.pop_front();
        if (!done_pre) begin
          for (int l = 0; l < N*N; l++)
            m_sum[l] = (t.f || !m_open) ? lane(i_result, l) : clamp(m_sum[l] + lane(i_result, l));
          m_open = !t.l;
          m_done = t.l;
        end
      end
      if (beat) begin
        if (fin) begin m_drain = 0; m_row = 0; end
        else m_row++;
      end
      if (swap) begin
        m_tile = m_sum; m_drain = 1; m_row = 0; m_done = 0; m_ready = 1; m_swaps++;
      end
      if (acc_i) begin
        pipe.push_back('{cyc + LAT, i_first, i_last});
        if (i_last) m_ready = 0;
      end
    end
    cyc++;
    #1;
    check("o_valid", o_valid, m_drain);
    check("o_issue_ready", o_issue_ready, m_ready);
    check("o_drop", o_drop, m_drop);
    if (m_drain) begin
      check("o_row", o_row, m_row);
      check("o_row_last", o_row_last, m_row == N-1);
      for (int x = 0; x < N; x++) er[x*OW +: OW] = OW'(m_tile[m_row*N + x]);
      n_cmp++;
      if (o_data !== er) begin
        n_fail++;
        $display("FAIL o_data row %0d: got %h, expected %h", m_row, o_data, er);
      end
    end else begin
      check("o_row_last_idle", o_row_last, 0);
    end
  end

  // caller sits at a negedge; returns one negedge later with the issue removed
  task automatic issue_tile(input bit f, input bit l, input logic [RB-1:0] v, input bit inj_drop);
    int n;
    n = 0;
    while (!o_issue_ready) begin
      if (n++ > 400) begin timeout_fail("issue_ready"); return; end
      i_issue = inj_drop && ($urandom_range(0, 7) == 0);
      i_first = 1; i_last = 1;
      @(negedge clk);
    end
    i_issue = 1; i_first = f; i_last = l;
    sched[cyc + LAT] = v;
    @(negedge clk);
    i_issue = 0; i_first = 0; i_last = 0;
  endtask

  task automatic wait_tiles(input int target);
    int n;
    n = 0;
    while (tiles_out < target) begin
      if (n++ > 2000) begin timeout_fail("tile_drain"); return; end
      @(negedge clk);
    end
  endtask

  task automatic check_tile(input string name, input longint lit);
    longint a, m;
    a = lit; m = lit;
    for (int i = N*N-1; i >= 0; i--) begin
      if (cap[i] != lit) a = cap[i];
      if (m_tile[i] != lit) m = m_tile[i];
    end
    check(name, a, lit);
    check({name, "_model"}, m, lit);
  endtask

  initial begin
    int t_last, n, base, bad;
    logic [N*OW-1:0] held;

    repeat (3) @(negedge clk);
    rst_n = 1;
    check("rst_o_valid", o_valid, 0);
    check("rst_o_issue_ready", o_issue_ready, 1);
    check("rst_o_drop", o_drop, 0);
    n_cmp++;
    if (o_data !== '0) begin n_fail++; $display("FAIL rst_o_data: got %h, expected 0", o_data); end
    repeat (20) @(negedge clk);
    check("idle_no_output", tiles_out, 0);

    // three-tile group, then an issue while blocked
    issue_tile(1, 0, uni(100), 0);
    issue_tile(0, 0, uni(200), 0);
    t_last = cyc;
    issue_tile(0, 1, uni(-50), 0);
    i_issue = 1; i_first = 1; i_last = 1;
    @(negedge clk);
    i_issue = 0; i_first = 0; i_last = 0;
    check("drop_sticky", o_drop, 1);
    n = 0;
    while (!o_valid && n < 60) begin n++; @(negedge clk); end
    check("first_valid_latency", cyc - t_last, LAT + 2);
    wait_tiles(1);
    check_tile("sum_250", 250);
    check("drop_still_set", o_drop, 1);

    // saturation both ways
    repeat (3) issue_tile(1'b0, 1'b0, uni(262143), 0);
    @(negedge clk);
    wait_tiles(1);
    base = tiles_out;
    issue_tile(1, 0, uni(262143), 0);
    issue_tile(0, 0, uni(262143), 0);
    issue_tile(0, 1, uni(262143), 0);
    wait_tiles(base + 1);
    check_tile("sat_pos", 524287);
    issue_tile(1, 0, uni(-262144), 0);
    issue_tile(0, 0, uni(-262144), 0);
    issue_tile(0, 1, uni(-262144), 0);
    wait_tiles(base + 2);
    check_tile("sat_neg", -524288);

    // back-pressure on row 3 while the next single-tile group lands
    base = tiles_out;
    issue_tile(1, 1, uni(11), 0);
    n = 0;
    while (!(o_valid && o_row == 3'd2) && n < 100) begin n++; @(negedge clk); end
    hold_rdy = 0;
    @(negedge clk);
    held = o_data;
    issue_tile(1, 1, uni(7), 0);
    bad = 0;
    for (int i = 0; i < 19; i++) begin
      if (!o_valid || o_row != 3'd3 || o_data !== held) bad++;
      @(negedge clk);
    end
    check("stall_row3_unstable_cycles", bad, 0);
    check("stall_issue_ready", o_issue_ready, 0);
    hold_rdy = 1;
    wait_tiles(base + 2);
    check_tile("after_stall_7", 7);

    // reset with two tiles in flight
    base = tiles_out;
    issue_tile(1, 0, uni(9), 0);
    issue_tile(0, 1, uni(9), 0);
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    repeat (30) @(negedge clk);
    check("reset_discards_inflight", tiles_out, base);
    check("reset_o_valid", o_valid, 0);
    issue_tile(1, 1, uni(5), 0);
    wait_tiles(base + 1);
    check_tile("post_reset_5", 5);

    // randomized groups with random back-pressure, restarts and dropped issues
    rand_rdy = 1;
    for (int g = 0; g < 10; g++) begin
      int k;
      k = $urandom_range(1, 4);
      for (int j = 0; j < k; j++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        issue_tile((j == 0) || ($urandom_range(0, 7) == 0), j == k-1, rnd_tile(), 1);
      end
    end
    rand_rdy = 0;
    n = 0;
    while ((m_done || m_drain || pipe.size() != 0 || tiles_out != m_swaps) && n < 3000) begin
      n++; @(negedge clk);
    end
    if (n >= 3000) timeout_fail("final_drain");
    check("tile_count", tiles_out, m_swaps);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
